apb_i2c_sched: RTL and testbench

- Sequencer and round-robin arbiter that shares one APB-attached I2C bridge among NREQ local requesters.
- Acts as APB master toward the bridge's APB slave port.
- For each granted single-byte request it performs a fixed register sequence: CON1, DATA, CON2/start, STAT polling, then a DOUT read when needed.
- Returns read data and error status to the requester, so clients never handle APB or I2C timing.

---
 rtl/apb_i2c_sched_if.sv | 21 ++
 rtl/apb_i2c_sched.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_apb_i2c_sched.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_i2c_sched_if.sv
// APB3 link between the I2C scheduler (master) and the I2C bridge register block (slave).
interface apb_i2c_sched_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_i2c_sched.sv
// Round-robin scheduler sharing one APB-attached I2C bridge among NREQ requesters.
// Each grant runs CON1, DIN (writes only), CON2 start, STAT polling and DOUT (reads only).
//
// state      | meaning
// -----------+---------------------------------------------------------
// S_IDLE     | no transaction; waits for any req
// S_ARB      | round-robin pick, latch requester fields, start CON1 setup
// S_W_CON1   | APB write of {addr, rw} to CON1
// S_W_DIN    | APB write of the data byte (write transactions only)
// S_W_CON2   | APB write of start bit; completion arms the timeout
// S_POLL_GAP | idle cycles between STAT reads; timeout checked here
// S_R_STAT   | APB read of STAT; decides done / NACK / poll again
// S_R_DOUT   | APB read of the received byte (read transactions only)
// S_DONE     | done pulse to the granted requester, gnt already low
module apb_i2c_sched #(
    parameter int          NREQ      = 4,
    parameter int          TIMEOUT   = 4096,
    parameter int          POLL_GAP  = 8,
    parameter logic [31:0] ADDR_CON1 = 32'h00,
    parameter logic [31:0] ADDR_CON2 = 32'h04,
    parameter logic [31:0] ADDR_DIN  = 32'h08,
    parameter logic [31:0] ADDR_STAT = 32'h0C,
    parameter logic [31:0] ADDR_DOUT = 32'h10
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     req_rw,
    input  logic [7*NREQ-1:0]   req_addr,
    input  logic [8*NREQ-1:0]   req_wdata,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     done,
    output logic [7:0]          rdata,
    output logic [1:0]          err,
    apb_i2c_sched_if.master     apb
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP + 1) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_ARB, S_W_CON1, S_W_DIN, S_W_CON2,
        S_POLL_GAP, S_R_STAT, S_R_DOUT, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic            rw_q, rw_d;
    logic [6:0]      addr_q, addr_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [7:0]      rdata_q, rdata_d;
    logic [1:0]      err_q, err_d;
    logic            psel_q, psel_d;
    logic            penable_q, penable_d;
    logic            pwrite_q, pwrite_d;
    logic [31:0]     paddr_q, paddr_d;
    logic [31:0]     pwdata_q, pwdata_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [GW-1:0]   gap_q, gap_d;

    logic [6:0]      addr_arr  [NREQ];
    logic [7:0]      wdata_arr [NREQ];
    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   arb_j;
    logic            start_acc;
    logic            fin;
    logic [1:0]      fin_err;
    logic            unused_prdata;

    assign unused_prdata = ^apb.PRDATA[31:8];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            addr_arr[i]  = req_addr[i*7 +: 7];
            wdata_arr[i] = req_wdata[i*8 +: 8];
        end
    end

    // Scan downward so the candidate nearest the pointer is the last one written.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        arb_j     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            arb_j = IW'((int'(ptr_q) + k) % NREQ);
            if (req[arb_j]) begin
                win_found = 1'b1;
                win_idx   = arb_j;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        rdata_d   = rdata_q;
        err_d     = err_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        tmo_d     = (tmo_q != '0) ? tmo_q - TW'(1) : tmo_q;
        gap_d     = gap_q;
        start_acc = 1'b0;
        fin       = 1'b0;
        fin_err   = 2'b00;

        case (state_q)
            S_IDLE: begin
                if (|req) state_d = S_ARB;
            end

            S_ARB: begin
                if (win_found) begin
                    state_d        = S_W_CON1;
                    start_acc      = 1'b1;
                    ptr_d          = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + IW'(1);
                    rw_d           = req_rw[win_idx];
                    addr_d         = addr_arr[win_idx];
                    wdata_d        = wdata_arr[win_idx];
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_W_CON1, S_W_DIN, S_W_CON2, S_R_STAT, S_R_DOUT: begin
                if (!penable_q) begin
                    penable_d = 1'b1;
                end else if (apb.PREADY) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    if (apb.PSLVERR) begin
                        fin     = 1'b1;
                        fin_err = 2'b10;
                    end else begin
                        case (state_q)
                            S_W_CON1: begin
                                state_d   = rw_q ? S_W_CON2 : S_W_DIN;
                                start_acc = 1'b1;
                            end
                            S_W_DIN: begin
                                state_d   = S_W_CON2;
                                start_acc = 1'b1;
                            end
                            S_W_CON2: begin
                                state_d = S_POLL_GAP;
                                gap_d   = GW'(POLL_GAP - 1);
                                tmo_d   = TW'(TIMEOUT);
                            end
                            S_R_STAT: begin
                                // A finished transfer wins over a timeout that expired mid-read.
                                if (apb.PRDATA[0]) begin
                                    if (apb.PRDATA[1]) begin
                                        fin     = 1'b1;
                                        fin_err = 2'b01;
                                    end else if (rw_q) begin
                                        state_d   = S_R_DOUT;
                                        start_acc = 1'b1;
                                    end else begin
                                        fin = 1'b1;
                                    end
                                end else if (tmo_q == '0) begin
                                    fin     = 1'b1;
                                    fin_err = 2'b11;
                                end else begin
                                    state_d = S_POLL_GAP;
                                    gap_d   = GW'(POLL_GAP - 1);
                                end
                            end
                            S_R_DOUT: begin
                                rdata_d = apb.PRDATA[7:0];
                                fin     = 1'b1;
                            end
                            default: begin
                                state_d = S_IDLE;
                            end
                        endcase
                    end
                end
            end

            S_POLL_GAP: begin
                if (tmo_q == '0) begin
                    fin     = 1'b1;
                    fin_err = 2'b11;
                end else if (gap_q == '0) begin
                    state_d   = S_R_STAT;
                    start_acc = 1'b1;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (fin) begin
            state_d   = S_DONE;
            done_d    = gnt_q;
            gnt_d     = '0;
            err_d     = fin_err;
            psel_d    = 1'b0;
            penable_d = 1'b0;
        end

        // Launch the SETUP phase of whichever access the FSM moves into.
        if (start_acc) begin
            psel_d    = 1'b1;
            penable_d = 1'b0;
            case (state_d)
                S_W_CON1: begin
                    pwrite_d = 1'b1;
                    paddr_d  = ADDR_CON1;
                    pwdata_d = {24'h0, addr_d, rw_d};
                end
                S_W_DIN: begin
                    pwrite_d = 1'b1;
                    paddr_d  = ADDR_DIN;
                    pwdata_d = {24'h0, wdata_d};
                end
                S_W_CON2: begin
                    pwrite_d = 1'b1;
                    paddr_d  = ADDR_CON2;
                    pwdata_d = 32'h1;
                end
                S_R_STAT: begin
                    pwrite_d = 1'b0;
                    paddr_d  = ADDR_STAT;
                    pwdata_d = 32'h0;
                end
                S_R_DOUT: begin
                    pwrite_d = 1'b0;
                    paddr_d  = ADDR_DOUT;
                    pwdata_d = 32'h0;
                end
                default: begin
                    psel_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            rdata_q   <= '0;
            err_q     <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            tmo_q     <= '0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            tmo_q     <= tmo_d;
            gap_q     <= gap_d;
        end
    end

    assign gnt         = gnt_q;
    assign done        = done_q;
    assign rdata       = rdata_q;
    assign err         = err_q;
    assign apb.PSEL    = psel_q;
    assign apb.PENABLE = penable_q;
    assign apb.PWRITE  = pwrite_q;
    assign apb.PADDR   = paddr_q;
    assign apb.PWDATA  = pwdata_q;

endmodule

// File: tb/tb_apb_i2c_sched.sv
// Directed bench for apb_i2c_sched with a behavioural APB bridge stub and access log.
module tb_apb_i2c_sched;

    localparam int NREQ = 4;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          en;
    } acc_t;

    logic                PCLK;
    logic                PRESET;
    logic [NREQ-1:0]     req;
    logic [NREQ-1:0]     req_rw;
    logic [7*NREQ-1:0]   req_addr;
    logic [8*NREQ-1:0]   req_wdata;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     done;
    logic [7:0]          rdata;
    logic [1:0]          err;

    apb_i2c_sched_if bus ();

    apb_i2c_sched #(.NREQ(NREQ), .TIMEOUT(64), .POLL_GAP(8)) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req       (req),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .apb       (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // bridge stub configuration
    int          ws_cfg = 0;
    int          stat_done_at = 1;
    logic [31:0] stat_val = 32'h1;
    logic [31:0] dout_val = 32'h0;
    logic        err_en = 1'b0;
    logic [31:0] err_addr = 32'h0;

    // monitors
    acc_t        log_q[$];
    int          stat_reads = 0;
    int          cyc = 0;
    int          con2_cyc = 0;
    int          en_cnt = 0;
    int          stab_viol = 0;
    int          onehot_viol = 0;
    int          done_gnt_viol = 0;
    int          done_cnt = 0;
    logic [NREQ-1:0] gnt_last = '0;
    logic        s_wr;
    logic [31:0] s_addr, s_data;

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        int wait_cnt;
        wait_cnt    = 0;
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
        bus.PRDATA  = 32'h0;
        forever begin
            @(negedge PCLK);
            if (bus.PSEL && bus.PENABLE) begin
                if (wait_cnt >= ws_cfg) begin
                    bus.PREADY  = 1'b1;
                    bus.PSLVERR = err_en && (bus.PADDR == err_addr);
                    if (bus.PADDR == 32'h0C)
                        bus.PRDATA = (stat_reads + 1 >= stat_done_at) ? stat_val : 32'h0;
                    else if (bus.PADDR == 32'h10)
                        bus.PRDATA = dout_val;
                    else
                        bus.PRDATA = 32'h0;
                end else begin
                    bus.PREADY = 1'b0;
                    wait_cnt++;
                end
            end else begin
                bus.PREADY  = 1'b0;
                bus.PSLVERR = 1'b0;
                wait_cnt    = 0;
            end
        end
    end

    always @(posedge PCLK) begin
        cyc++;
        if (bus.PSEL && !bus.PENABLE) begin
            s_wr   = bus.PWRITE;
            s_addr = bus.PADDR;
            s_data = bus.PWDATA;
        end
        if (bus.PSEL && bus.PENABLE) begin
            en_cnt++;
            if (bus.PWRITE !== s_wr || bus.PADDR !== s_addr || bus.PWDATA !== s_data)
                stab_viol++;
            if (bus.PREADY) begin
                log_q.push_back('{bus.PWRITE, bus.PADDR,
                                  bus.PWRITE ? bus.PWDATA : bus.PRDATA, en_cnt});
                en_cnt = 0;
                if (bus.PWRITE && bus.PADDR == 32'h04) begin
                    stat_reads = 0;
                    con2_cyc   = cyc;
                end
                if (!bus.PWRITE && bus.PADDR == 32'h0C) stat_reads++;
            end
        end else begin
            en_cnt = 0;
        end
    end

    always @(negedge PCLK) begin
        if ($countones(gnt) > 1) onehot_viol++;
        if (done !== '0) begin
            done_cnt++;
            if (done !== gnt_last) done_gnt_viol++;
        end
        if (gnt !== '0) gnt_last = gnt;
    end

    task automatic set_req(input int i, input logic rw, input logic [6:0] a, input logic [7:0] d);
        req_rw[i]          = rw;
        req_addr[i*7 +: 7] = a;
        req_wdata[i*8 +: 8] = d;
    endtask

    task automatic wait_done(input int budget, output logic [NREQ-1:0] d, output logic [1:0] e,
                             output logic [7:0] r, output logic [NREQ-1:0] g, output int c);
        d = '0; e = '0; r = '0; g = '0; c = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge PCLK);
            if (done !== '0) begin
                d = done; e = err; r = rdata; g = gnt; c = cyc;
                break;
            end
        end
        vectors++;
        if (d === '0) begin
            miscompares++;
            $display("FAIL wait_done: no done pulse within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        PRESET = 1'b1;
        req = 4'b0001;
        repeat (3) @(negedge PCLK);
        vectors++;
        if ({gnt, done, rdata, err} !== '0) begin
            miscompares++;
            $display("FAIL reset_outs: gnt=%b done=%b rdata=%h err=%b want all 0", gnt, done, rdata, err);
        end
        vectors++;
        if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA} !== '0) begin
            miscompares++;
            $display("FAIL reset_apb: PSEL=%b PENABLE=%b PADDR=%h PWDATA=%h want 0",
                     bus.PSEL, bus.PENABLE, bus.PADDR, bus.PWDATA);
        end
        req = '0;
        PRESET = 1'b0;
        repeat (2) @(negedge PCLK);
    endtask

    task automatic test_write();
        logic [NREQ-1:0] d, g;
        logic [1:0] e;
        logic [7:0] r;
        int c;
        acc_t ex[5];
        ex[0] = '{1'b1, 32'h00, 32'hA0, 1};
        ex[1] = '{1'b1, 32'h08, 32'hA5, 1};
        ex[2] = '{1'b1, 32'h04, 32'h01, 1};
        ex[3] = '{1'b0, 32'h0C, 32'h00, 1};
        ex[4] = '{1'b0, 32'h0C, 32'h01, 1};
        ws_cfg = 0; stat_done_at = 2; stat_val = 32'h1;
        log_q.delete();
        set_req(0, 1'b0, 7'h50, 8'hA5);
        req = 4'b0001;
        wait_done(200, d, e, r, g, c);
        req = '0;
        vectors++;
        if (d !== 4'b0001 || e !== 2'b00 || g !== 4'b0000) begin
            miscompares++;
            $display("FAIL write_done: done=%b err=%b gnt=%b want 0001 00 0000", d, e, g);
        end
        @(negedge PCLK);
        vectors++;
        if (done !== '0) begin
            miscompares++;
            $display("FAIL write_pulse: done=%b one cycle after pulse, want 0000", done);
        end
        vectors++;
        if (log_q.size() != 5) begin
            miscompares++;
            $display("FAIL write_log_len: got %0d accesses want 5", log_q.size());
        end
        for (int i = 0; i < 5 && i < log_q.size(); i++) begin
            vectors++;
            if (log_q[i].wr !== ex[i].wr || log_q[i].addr !== ex[i].addr ||
                log_q[i].data !== ex[i].data || log_q[i].en != ex[i].en) begin
                miscompares++;
                $display("FAIL write_acc%0d: wr=%b addr=%h data=%h en=%0d want wr=%b addr=%h data=%h en=%0d",
                         i, log_q[i].wr, log_q[i].addr, log_q[i].data, log_q[i].en,
                         ex[i].wr, ex[i].addr, ex[i].data, ex[i].en);
            end
        end
    endtask

    task automatic test_read_wait();
        logic [NREQ-1:0] d, g;
        logic [1:0] e;
        logic [7:0] r;
        int c;
        acc_t ex[4];
        ex[0] = '{1'b1, 32'h00, 32'h79, 3};
        ex[1] = '{1'b1, 32'h04, 32'h01, 3};
        ex[2] = '{1'b0, 32'h0C, 32'h01, 3};
        ex[3] = '{1'b0, 32'h10, 32'h5A, 3};
        ws_cfg = 2; stat_done_at = 1; stat_val = 32'h1; dout_val = 32'h5A;
        log_q.delete();
        set_req(2, 1'b1, 7'h3C, 8'h00);
        req = 4'b0100;
        wait_done(300, d, e, r, g, c);
        req = '0;
        vectors++;
        if (d !== 4'b0100 || e !== 2'b00 || r !== 8'h5A) begin
            miscompares++;
            $display("FAIL read_done: done=%b err=%b rdata=%h want 0100 00 5a", d, e, r);
        end
        vectors++;
        if (log_q.size() != 4) begin
            miscompares++;
            $display("FAIL read_log_len: got %0d accesses want 4", log_q.size());
        end
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            vectors++;
            if (log_q[i].wr !== ex[i].wr || log_q[i].addr !== ex[i].addr ||
                log_q[i].data !== ex[i].data || log_q[i].en != ex[i].en) begin
                miscompares++;
                $display("FAIL read_acc%0d: wr=%b addr=%h data=%h en=%0d want wr=%b addr=%h data=%h en=%0d",
                         i, log_q[i].wr, log_q[i].addr, log_q[i].data, log_q[i].en,
                         ex[i].wr, ex[i].addr, ex[i].data, ex[i].en);
            end
        end
        repeat (3) @(negedge PCLK);
        vectors++;
        if (rdata !== 8'h5A) begin
            miscompares++;
            $display("FAIL read_hold: rdata=%h after done, want 5a", rdata);
        end
        ws_cfg = 0;
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] d, g;
        logic [1:0] e;
        logic [7:0] r;
        int c;
        logic [NREQ-1:0] ex[5];
        ex[0] = 4'b0001; ex[1] = 4'b0010; ex[2] = 4'b0100; ex[3] = 4'b1000; ex[4] = 4'b0001;
        PRESET = 1'b1;
        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;
        ws_cfg = 0; stat_done_at = 1; stat_val = 32'h1;
        onehot_viol = 0; done_gnt_viol = 0;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 7'(7'h10 + i), 8'(8'hC0 + i));
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            wait_done(200, d, e, r, g, c);
            if (t == 4) req = '0;
            vectors++;
            if (d !== ex[t] || e !== 2'b00) begin
                miscompares++;
                $display("FAIL rr_order%0d: done=%b err=%b want %b 00", t, d, e, ex[t]);
            end
        end
        vectors++;
        if (onehot_viol != 0 || done_gnt_viol != 0 || stab_viol != 0) begin
            miscompares++;
            $display("FAIL rr_integrity: onehot_viol=%0d done_gnt_viol=%0d apb_stab_viol=%0d want 0 0 0",
                     onehot_viol, done_gnt_viol, stab_viol);
        end
        repeat (3) @(negedge PCLK);
    endtask

    task automatic test_nack();
        logic [NREQ-1:0] d, g;
        logic [1:0] e;
        logic [7:0] r;
        int c;
        int douts;
        ws_cfg = 0; stat_done_at = 1; stat_val = 32'h3; dout_val = 32'hEE;
        log_q.delete();
        set_req(1, 1'b1, 7'h22, 8'h00);
        req = 4'b0010;
        wait_done(200, d, e, r, g, c);
        req = '0;
        vectors++;
        if (d !== 4'b0010 || e !== 2'b01) begin
            miscompares++;
            $display("FAIL nack_done: done=%b err=%b want 0010 01", d, e);
        end
        douts = 0;
        foreach (log_q[i]) if (log_q[i].addr == 32'h10) douts++;
        vectors++;
        if (douts != 0 || log_q.size() != 3) begin
            miscompares++;
            $display("FAIL nack_log: dout_reads=%0d accesses=%0d want 0 3", douts, log_q.size());
        end
        repeat (3) @(negedge PCLK);
    endtask

    task automatic test_timeout();
        logic [NREQ-1:0] d, g;
        logic [1:0] e;
        logic [7:0] r;
        int c;
        ws_cfg = 0; stat_done_at = 100000; stat_val = 32'h1;
        set_req(3, 1'b0, 7'h11, 8'h77);
        req = 4'b1000;
        wait_done(400, d, e, r, g, c);
        req = '0;
        vectors++;
        if (d !== 4'b1000 || e !== 2'b11) begin
            miscompares++;
            $display("FAIL tmo_done: done=%b err=%b want 1000 11", d, e);
        end
        vectors++;
        if (c - con2_cyc < 60 || c - con2_cyc > 72) begin
            miscompares++;
            $display("FAIL tmo_latency: %0d cycles from CON2 to done, want 60..72", c - con2_cyc);
        end
        repeat (3) @(negedge PCLK);
    endtask

    task automatic test_pslverr();
        logic [NREQ-1:0] d, g;
        logic [1:0] e;
        logic [7:0] r;
        int c;
        int psel_hi;
        ws_cfg = 0; stat_done_at = 1; stat_val = 32'h1;
        err_en = 1'b1; err_addr = 32'h00;
        log_q.delete();
        set_req(0, 1'b0, 7'h33, 8'h44);
        req = 4'b0001;
        wait_done(100, d, e, r, g, c);
        req = '0;
        err_en = 1'b0;
        vectors++;
        if (d !== 4'b0001 || e !== 2'b10) begin
            miscompares++;
            $display("FAIL slverr_done: done=%b err=%b want 0001 10", d, e);
        end
        psel_hi = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge PCLK);
            if (bus.PSEL) psel_hi++;
        end
        vectors++;
        if (psel_hi != 0 || log_q.size() != 1) begin
            miscompares++;
            $display("FAIL slverr_quiet: psel_cycles=%0d accesses=%0d want 0 1", psel_hi, log_q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [NREQ-1:0] d, g;
        logic [1:0] e;
        logic [7:0] r;
        int c;
        int dc0;
        bit seen;
        ws_cfg = 2; stat_done_at = 100000; stat_val = 32'h1;
        set_req(0, 1'b1, 7'h05, 8'h00);
        set_req(1, 1'b0, 7'h06, 8'h99);
        req = 4'b0001;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge PCLK);
            if (bus.PSEL && bus.PENABLE && bus.PADDR == 32'h0C) seen = 1;
            if (gnt === 4'b0001) req = 4'b0011;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL rstmid_reach: no STAT access within 200 cycles");
        end
        dc0 = done_cnt;
        PRESET = 1'b1;
        req = 4'b0010;
        stat_done_at = 1;
        @(negedge PCLK);
        vectors++;
        if (bus.PSEL !== 1'b0 || bus.PENABLE !== 1'b0 || gnt !== '0 || done !== '0) begin
            miscompares++;
            $display("FAIL rstmid_abort: PSEL=%b PENABLE=%b gnt=%b done=%b want 0 0 0000 0000",
                     bus.PSEL, bus.PENABLE, gnt, done);
        end
        @(negedge PCLK);
        PRESET = 1'b0;
        ws_cfg = 0;
        g = '0;
        for (int i = 0; i < 10 && g === '0; i++) begin
            @(negedge PCLK);
            g = gnt;
        end
        vectors++;
        if (g !== 4'b0010 || done_cnt != dc0) begin
            miscompares++;
            $display("FAIL rstmid_regrant: gnt=%b dones_during_reset=%0d want 0010 0", g, done_cnt - dc0);
        end
        wait_done(200, d, e, r, g, c);
        req = '0;
        vectors++;
        if (d !== 4'b0010 || e !== 2'b00) begin
            miscompares++;
            $display("FAIL rstmid_done: done=%b err=%b want 0010 00", d, e);
        end
        repeat (3) @(negedge PCLK);
    endtask

    initial begin
        PRESET    = 1'b1;
        req       = '0;
        req_rw    = '0;
        req_addr  = '0;
        req_wdata = '0;
        test_reset();
        test_write();
        test_read_wait();
        test_round_robin();
        test_nack();
        test_timeout();
        test_pslverr();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
